// File: rtl/fnd_pkg.sv
//------------------------------------------------------------------------------
// fnd_pkg
//
// Shared constants for the FND (7-segment) display path.
//   - Active-low segment fonts for the digits 0..9, the decimal point alone,
//     and the blank pattern.
//   - The idle value of the active-low digit-select bus.
//   - The 4-bit codes reported for blank and undecodable fonts.
//   - Helpers that classify a digit-select value.
//
// The BCD->FND encoder on the writer side uses the same font constants, so
// both directions of the loopback share one table.
//------------------------------------------------------------------------------
package fnd_pkg;

    // Segment fonts, active-low, bit7 = dp, bits6..0 = g..a.
    localparam logic [7:0] FONT_0     = 8'hc0;
    localparam logic [7:0] FONT_1     = 8'hf9;
    localparam logic [7:0] FONT_2     = 8'ha4;
    localparam logic [7:0] FONT_3     = 8'hb0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hf8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_DP    = 8'h7f;
    localparam logic [7:0] FONT_BLANK = 8'hff;

    // Digit select with no digit driven (inter-digit blanking).
    localparam logic [3:0] COM_IDLE   = 4'hf;

    // Codes that are not plain decimal digits.
    localparam logic [3:0] CODE_DP    = 4'ha;
    localparam logic [3:0] CODE_BAD   = 4'he;
    localparam logic [3:0] CODE_BLANK = 4'hf;

    // Number of multiplexed digits on the display.
    localparam int unsigned NUM_DIGITS = 4;

    // Classification of a sampled digit-select value.
    typedef enum logic [1:0] {
        COM_KIND_IDLE   = 2'd0,  // 4'hf, blanking between digits
        COM_KIND_DIGIT  = 2'd1,  // exactly one bit low
        COM_KIND_ILLEGAL = 2'd2  // no bit low or several bits low
    } com_kind_e;

    // The select bus is active-low one-hot: a legal digit has exactly one
    // zero, i.e. its complement is one-hot.
    function automatic com_kind_e classify_com(input logic [3:0] com);
        if (com == COM_IDLE)
            return COM_KIND_IDLE;
        else if ($onehot(~com))
            return COM_KIND_DIGIT;
        else
            return COM_KIND_ILLEGAL;
    endfunction

endpackage : fnd_pkg

// File: rtl/fnd_font_to_bcd_monitor_if.sv
//------------------------------------------------------------------------------
// fnd_font_to_bcd_monitor_if
//
// The multiplexed FND display bus as seen on the board.
//   i_com  [3:0] : digit select, active-low one-hot, 4'hf = blanking
//   i_font [7:0] : segment font, active-low, bit7 = dp
//
// Modports:
//   master : the display driver that owns the bus
//   slave  : a passive observer (the font-to-BCD monitor)
//------------------------------------------------------------------------------
interface fnd_font_to_bcd_monitor_if;

    logic [3:0] i_com;
    logic [7:0] i_font;

    modport master (
        output i_com,
        output i_font
    );

    modport slave (
        input i_com,
        input i_font
    );

endinterface : fnd_font_to_bcd_monitor_if

// File: rtl/fnd_font_decode.sv
//------------------------------------------------------------------------------
// fnd_font_decode
//
// Combinational inverse of the BCD->FND font table. Every bit of the font,
// including dp, must match exactly; anything else is reported as CODE_BAD
// with the illegal flag raised.
//
// Ports:
//   font    in   8  active-low segment font
//   code    out  4  decoded code (0..9, A = dp only, F = blank, E = bad)
//   illegal out  1  font is not in the table
//------------------------------------------------------------------------------
module fnd_font_decode
    import fnd_pkg::*;
(
    input  logic [7:0] font,
    output logic [3:0] code,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through the block leaves a value held, which would infer a latch.
        code    = CODE_BAD;
        illegal = 1'b0;
        case (font)
            FONT_0:     code = 4'h0;
            FONT_1:     code = 4'h1;
            FONT_2:     code = 4'h2;
            FONT_3:     code = 4'h3;
            FONT_4:     code = 4'h4;
            FONT_5:     code = 4'h5;
            FONT_6:     code = 4'h6;
            FONT_7:     code = 4'h7;
            FONT_8:     code = 4'h8;
            FONT_9:     code = 4'h9;
            FONT_DP:    code = CODE_DP;
            FONT_BLANK: code = CODE_BLANK;
            default: begin
                code    = CODE_BAD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule : fnd_font_decode

// File: rtl/fnd_font_to_bcd_monitor.sv
//------------------------------------------------------------------------------
// fnd_font_to_bcd_monitor
//
// Passive reader of the multiplexed FND display. It waits for each
// digit-select/font pair to settle, decodes the font back to a 4-bit code,
// assembles the four digits into a frame and publishes a frame only when two
// consecutive frames agree, which filters out the moment the display value
// is being rewritten.
//
// Ports:
//   i_clk     in   1   system clock
//   i_reset   in   1   synchronous reset, active-high
//   bus       slave    snooped display bus (i_com, i_font)
//   o_bcd     out  16  last published frame, digit n in [4n+3:4n]
//   o_valid   out  1   o_bcd holds a published frame
//   o_update  out  1   one-cycle pulse when o_bcd takes a new value
//   o_err     out  1   sticky: illegal font or illegal digit select seen
//
// Parameters:
//   SETTLE_CYC : cycles a pair must stay unchanged before it is sampled
//   CNT_W      : settle counter width, 2**CNT_W must exceed SETTLE_CYC
//------------------------------------------------------------------------------
module fnd_font_to_bcd_monitor
    import fnd_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 3
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    fnd_font_to_bcd_monitor_if.slave       bus,
    output logic [4*NUM_DIGITS-1:0]        o_bcd,
    output logic                           o_valid,
    output logic                           o_update,
    output logic                           o_err
);

    localparam int                 FRAME_W     = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0]   SETTLE_MAX  = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [NUM_DIGITS-1:0] MASK_FULL = '1;

    //--------------------------------------------------------------------------
    // Settle tracking
    //--------------------------------------------------------------------------
    logic [3:0]       com_q;
    logic [7:0]       font_q;
    logic [CNT_W-1:0] settle_cnt;
    logic             changed;
    logic             sample;

    assign changed = (bus.i_com != com_q) || (bus.i_font != font_q);

    // The event fires on the edge where the counter steps onto SETTLE_CYC.
    // Once there the counter saturates, so a long hold samples only once.
    assign sample = !changed && (settle_cnt == SETTLE_LAST);

    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // flop sees the pre-edge value of every other flop, independent of
        // statement order.
        if (i_reset) begin
            com_q      <= COM_IDLE;
            font_q     <= FONT_BLANK;
            settle_cnt <= '0;
        end else begin
            com_q  <= bus.i_com;
            font_q <= bus.i_font;
            if (changed)
                settle_cnt <= '0;
            else if (settle_cnt != SETTLE_MAX)
                settle_cnt <= settle_cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Font decode and sample classification
    //--------------------------------------------------------------------------
    logic [3:0]            dec_code;
    logic                  dec_illegal;
    com_kind_e             com_kind;
    logic                  capture;
    logic [NUM_DIGITS-1:0] cap_bits;
    logic                  bad_com;
    logic                  bad_font;

    fnd_font_decode u_decode (
        .font    (bus.i_font),
        .code    (dec_code),
        .illegal (dec_illegal)
    );

    assign com_kind = classify_com(bus.i_com);
    assign capture  = sample && (com_kind == COM_KIND_DIGIT);
    // Active-low select inverted gives the one-hot digit position.
    assign cap_bits = capture ? ~bus.i_com : '0;
    assign bad_com  = sample && (com_kind == COM_KIND_ILLEGAL);
    assign bad_font = capture && dec_illegal;

    //--------------------------------------------------------------------------
    // Frame assembly
    //--------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] mask;
    logic [FRAME_W-1:0]    stage;
    logic [FRAME_W-1:0]    prev;
    logic                  prev_filled;
    logic                  frame_close;

    // The close is seen one cycle after the capture that filled the mask,
    // so a capture and a close never land on the same edge for the same
    // frame.
    assign frame_close = (mask == MASK_FULL);

    always_ff @(posedge i_clk) begin
        // NOTE: stage and prev are a few plain flops rather than a memory,
        // so they are cleared on reset like any other state.
        if (i_reset) begin
            mask        <= '0;
            stage       <= '0;
            prev        <= '0;
            prev_filled <= 1'b0;
        end else begin
            // Clear first, then set: a capture on the close cycle opens the
            // next frame instead of being lost.
            mask <= (frame_close ? '0 : mask) | cap_bits;

            for (int n = 0; n < NUM_DIGITS; n++) begin
                if (cap_bits[n])
                    stage[4*n +: 4] <= dec_code;
            end

            if (frame_close) begin
                prev        <= stage;
                prev_filled <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Publish: one cycle after the close of the second matching frame.
    // The closed frame is copied aside because stage may already be taking
    // captures for the next frame.
    //--------------------------------------------------------------------------
    logic               pub_pend;
    logic [FRAME_W-1:0] pub_bcd;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pub_pend <= 1'b0;
            pub_bcd  <= '0;
            o_bcd    <= '0;
            o_valid  <= 1'b0;
            o_update <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            pub_pend <= frame_close && prev_filled && (stage == prev);
            if (frame_close)
                pub_bcd <= stage;

            o_update <= pub_pend && (pub_bcd != o_bcd);
            if (pub_pend) begin
                o_bcd   <= pub_bcd;
                o_valid <= 1'b1;
            end

            // Sticky; independent of publishing so both can happen at once.
            if (bad_com || bad_font)
                o_err <= 1'b1;
        end
    end

endmodule : fnd_font_to_bcd_monitor

// File: tb/tb_fnd_font_to_bcd_monitor.sv
//------------------------------------------------------------------------------
// tb_fnd_font_to_bcd_monitor
//
// Drives scans of the multiplexed display and compares the monitor outputs
// with expected values derived from the font table and the two-frame publish
// rule.
//------------------------------------------------------------------------------
module tb_fnd_font_to_bcd_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] o_bcd;
    logic        o_valid;
    logic        o_update;
    logic        o_err;

    always #5 clk = ~clk;

    fnd_font_to_bcd_monitor_if bus ();

    fnd_font_to_bcd_monitor #(
        .SETTLE_CYC (4),
        .CNT_W      (3)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .bus      (bus),
        .o_bcd    (o_bcd),
        .o_valid  (o_valid),
        .o_update (o_update),
        .o_err    (o_err)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int upd_cnt      = 0;

    // Count update pulses away from the active edge.
    always @(negedge clk) if (o_update === 1'b1) upd_cnt++;

    // Frames packed as digit3..digit0 fonts.
    localparam logic [31:0] S1234 = {8'h99, 8'hb0, 8'ha4, 8'hf9};
    localparam logic [31:0] S5234 = {8'h99, 8'hb0, 8'ha4, 8'h92};
    localparam logic [31:0] SBAD1 = {8'h99, 8'hb0, 8'h55, 8'hf9};

    // Reference font table from the display definition.
    logic [7:0] font_tab [12] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92,
                                  8'h82, 8'hf8, 8'h80, 8'h90, 8'h7f, 8'hff};
    logic [3:0] code_tab [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                  4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hf};

    function automatic logic [3:0] ref_code(input logic [7:0] f);
        for (int i = 0; i < 12; i++)
            if (font_tab[i] == f) return code_tab[i];
        return 4'he;
    endfunction

    function automatic logic [15:0] ref_frame(input logic [31:0] f);
        logic [15:0] r;
        for (int n = 0; n < 4; n++) r[4*n +: 4] = ref_code(f[8*n +: 8]);
        return r;
    endfunction

    // Frame-level model of the published outputs.
    logic [15:0] m_bcd, m_prev;
    logic        m_valid, m_prev_ok;
    int          m_upd;

    task automatic model_reset();
        m_bcd = '0; m_prev = '0; m_valid = 0; m_prev_ok = 0; m_upd = 0;
    endtask

    task automatic model_frame(input logic [15:0] fr);
        if (m_prev_ok && fr == m_prev) begin
            if (fr != m_bcd) m_upd++;
            m_bcd   = fr;
            m_valid = 1;
        end
        m_prev    = fr;
        m_prev_ok = 1;
    endtask

    // Inputs change 1 time unit after a rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] com, input logic [7:0] font, input int n);
        bus.i_com  = com;
        bus.i_font = font;
        wait_cyc(n);
    endtask

    task automatic scan(input logic [31:0] f, input int hold = 8, input int gap = 2);
        for (int n = 0; n < 4; n++) begin
            drive(~(4'b0001 << n), f[8*n +: 8], hold);
            drive(4'hf, 8'hff, gap);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'hf, 8'hff, 2);
        rst = 1'b0;
    endtask

    //--------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        tests_run++; if (o_bcd !== 16'h0) begin tests_failed++;
            $display("FAIL reset_bcd got %h want 0000", o_bcd); end
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++;
            $display("FAIL reset_valid got %b want 0", o_valid); end
        tests_run++; if (o_update !== 1'b0) begin tests_failed++;
            $display("FAIL reset_update got %b want 0", o_update); end
        tests_run++; if (o_err !== 1'b0) begin tests_failed++;
            $display("FAIL reset_err got %b want 0", o_err); end
    endtask

    task automatic test_scan_1234();
        int u0 = upd_cnt;
        scan(S1234);
        wait_cyc(2);
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++;
            $display("FAIL scan_one_frame_valid got %b want 0", o_valid); end
        scan(S1234);
        wait_cyc(2);
        tests_run++; if (o_bcd !== 16'h4321) begin tests_failed++;
            $display("FAIL scan_bcd got %h want 4321", o_bcd); end
        tests_run++; if (o_valid !== 1'b1) begin tests_failed++;
            $display("FAIL scan_valid got %b want 1", o_valid); end
        tests_run++; if (upd_cnt - u0 !== 1) begin tests_failed++;
            $display("FAIL scan_updates got %0d want 1", upd_cnt - u0); end
        tests_run++; if (o_err !== 1'b0) begin tests_failed++;
            $display("FAIL scan_err got %b want 0", o_err); end
    endtask

    task automatic test_steady();
        int u0 = upd_cnt;
        repeat (10) scan(S1234);
        wait_cyc(2);
        tests_run++; if (upd_cnt - u0 !== 0) begin tests_failed++;
            $display("FAIL steady_updates got %0d want 0", upd_cnt - u0); end
        tests_run++; if (o_bcd !== 16'h4321) begin tests_failed++;
            $display("FAIL steady_bcd got %h want 4321", o_bcd); end
    endtask

    task automatic test_change();
        int u0 = upd_cnt;
        scan(S5234);
        wait_cyc(2);
        tests_run++; if (o_bcd !== 16'h4321) begin tests_failed++;
            $display("FAIL change_first_frame_bcd got %h want 4321", o_bcd); end
        scan(S5234);
        wait_cyc(2);
        tests_run++; if (o_bcd !== 16'h4325) begin tests_failed++;
            $display("FAIL change_bcd got %h want 4325", o_bcd); end
        tests_run++; if (upd_cnt - u0 !== 1) begin tests_failed++;
            $display("FAIL change_updates got %0d want 1", upd_cnt - u0); end
    endtask

    // Digit 2 held long enough to sample, then a 2-cycle font glitch that
    // must not be sampled (it would otherwise overwrite digit 2 with 8).
    task automatic test_glitch();
        int u0 = upd_cnt;
        repeat (2) begin
            drive(4'he, 8'h92, 8); drive(4'hf, 8'hff, 2);
            drive(4'hd, 8'ha4, 8); drive(4'hf, 8'hff, 2);
            drive(4'hb, 8'hb0, 8); drive(4'hb, 8'h80, 2);
            drive(4'hf, 8'hff, 2);
            drive(4'h7, 8'h99, 8); drive(4'hf, 8'hff, 2);
        end
        wait_cyc(2);
        tests_run++; if (o_bcd !== 16'h4325) begin tests_failed++;
            $display("FAIL glitch_bcd got %h want 4325", o_bcd); end
        tests_run++; if (o_err !== 1'b0) begin tests_failed++;
            $display("FAIL glitch_err got %b want 0", o_err); end
        tests_run++; if (upd_cnt - u0 !== 0) begin tests_failed++;
            $display("FAIL glitch_updates got %0d want 0", upd_cnt - u0); end
    endtask

    // 4'hc between digits 2 and 3: must flag an error and capture nothing.
    task automatic test_bad_com();
        do_reset();
        repeat (2) begin
            for (int n = 0; n < 3; n++) begin
                drive(~(4'b0001 << n), S1234[8*n +: 8], 8);
                drive(4'hf, 8'hff, 2);
            end
            drive(4'hc, 8'h82, 8); drive(4'hf, 8'hff, 2);
            drive(4'h7, 8'h99, 8); drive(4'hf, 8'hff, 2);
        end
        wait_cyc(2);
        tests_run++; if (o_err !== 1'b1) begin tests_failed++;
            $display("FAIL bad_com_err got %b want 1", o_err); end
        tests_run++; if (o_bcd !== 16'h4321) begin tests_failed++;
            $display("FAIL bad_com_bcd got %h want 4321", o_bcd); end
        tests_run++; if (o_valid !== 1'b1) begin tests_failed++;
            $display("FAIL bad_com_valid got %b want 1", o_valid); end
    endtask

    task automatic test_bad_font();
        do_reset();
        tests_run++; if (o_err !== 1'b0) begin tests_failed++;
            $display("FAIL bad_font_pre_err got %b want 0", o_err); end
        scan(SBAD1);
        scan(SBAD1);
        wait_cyc(2);
        tests_run++; if (o_bcd !== 16'h43e1) begin tests_failed++;
            $display("FAIL bad_font_bcd got %h want 43e1", o_bcd); end
        tests_run++; if (o_err !== 1'b1) begin tests_failed++;
            $display("FAIL bad_font_err got %b want 1", o_err); end
        scan(S1234);
        scan(S1234);
        wait_cyc(2);
        tests_run++; if (o_bcd !== 16'h4321) begin tests_failed++;
            $display("FAIL bad_font_recover_bcd got %h want 4321", o_bcd); end
        tests_run++; if (o_err !== 1'b1) begin tests_failed++;
            $display("FAIL bad_font_sticky_err got %b want 1", o_err); end
    endtask

    task automatic test_mid_reset();
        scan(S1234);
        for (int n = 0; n < 3; n++) begin
            drive(~(4'b0001 << n), S1234[8*n +: 8], 8);
            drive(4'hf, 8'hff, 2);
        end
        rst = 1'b1;
        wait_cyc(1);
        tests_run++; if ({o_bcd, o_valid, o_update, o_err} !== 19'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs got bcd=%h v=%b u=%b e=%b want all 0",
                     o_bcd, o_valid, o_update, o_err);
        end
        rst = 1'b0;
        scan(S1234);
        wait_cyc(2);
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++;
            $display("FAIL mid_reset_one_frame_valid got %b want 0", o_valid); end
        scan(S1234);
        wait_cyc(2);
        tests_run++; if (o_valid !== 1'b1 || o_bcd !== 16'h4321) begin tests_failed++;
            $display("FAIL mid_reset_two_frames got v=%b bcd=%h want v=1 bcd=4321",
                     o_valid, o_bcd); end
    endtask

    task automatic test_random();
        logic [31:0] f, last;
        int u0;
        do_reset();
        model_reset();
        u0   = upd_cnt;
        last = S1234;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 9) < 5) f = last;
            else for (int n = 0; n < 4; n++) f[8*n +: 8] = font_tab[$urandom_range(0, 11)];
            scan(f, int'($urandom_range(6, 10)), int'($urandom_range(1, 3)));
            wait_cyc(2);
            model_frame(ref_frame(f));
            last = f;
            tests_run++; if (o_bcd !== m_bcd) begin tests_failed++;
                $display("FAIL random_bcd[%0d] got %h want %h", k, o_bcd, m_bcd); end
            tests_run++; if (o_valid !== m_valid) begin tests_failed++;
                $display("FAIL random_valid[%0d] got %b want %b", k, o_valid, m_valid); end
            tests_run++; if (upd_cnt - u0 !== m_upd) begin tests_failed++;
                $display("FAIL random_updates[%0d] got %0d want %0d", k, upd_cnt - u0, m_upd); end
            tests_run++; if (o_err !== 1'b0) begin tests_failed++;
                $display("FAIL random_err[%0d] got %b want 0", k, o_err); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.i_com  = 4'hf;
        bus.i_font = 8'hff;
        test_reset();
        test_scan_1234();
        test_steady();
        test_change();
        test_glitch();
        test_bad_com();
        test_bad_font();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_fnd_font_to_bcd_monitor

// File: doc/fnd_font_to_bcd_monitor.md
Name: fnd_font_to_bcd_monitor

Overview:
- Reader side of the FND display path. Snoops the multiplexed, active-low 4-digit digit-select bus and the 8-bit active-low font bus that drive the 7-segment display.
- Decodes each font back into its 4-bit code and assembles a 4-digit frame.
- Publishes a frame only after two consecutive identical frames, with valid and error flags.
- Used for loopback self-check of the timer display and for reporting the shown value back to the MCU.

Parameters:
- SETTLE_CYC, 4: consecutive i_clk cycles that a digit-select and font pair must hold unchanged before it is sampled.
- CNT_W, 3: width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYC.

Ports:
- i_clk      in   1   system clock
- i_reset    in   1   synchronous reset, active-high
- i_com      in   4   digit select, active-low one-hot; bit n low = digit n driven; 4'hf = inter-digit blanking
- i_font     in   8   segment font, active-low, bit7 = dp
- o_bcd      out  16  last published frame; digit n in [4n+3:4n]
- o_valid    out  1   high while o_bcd holds a published frame
- o_update   out  1   one-cycle pulse when o_bcd changes value
- o_err      out  1   sticky; set on illegal font or illegal i_com; cleared only by reset

Behaviour:
- Reset (sync, i_reset=1 at a rising edge):
  - o_bcd=16'h0000, o_valid=0, o_update=0, o_err=0.
  - Settle counter, capture mask, staging frame and previous frame all cleared. Reset mid-frame discards the partial capture.
- Font decode, combinational, full 8-bit match:
  - c0→0, f9→1, a4→2, b0→3, 99→4, 92→5, 82→6, f8→7, 80→8, 90→9, 7f→A (dp only), ff→F (blank).
  - Any other font → code E and illegal flag.
- Settle tracking:
  - Register i_com and i_font each cycle.
  - If either differs from its registered copy, counter=0; else the counter increments, saturating at SETTLE_CYC.
  - Sample event fires on the cycle the counter reaches SETTLE_CYC. It fires once per stable interval, not repeatedly.
- On a sample event, by i_com value:
  - 4'hf: ignored; no capture.
  - Exactly one bit low (digit n): stage[n]=decoded code; mask[n]=1. Illegal font also sets o_err. Recapturing the same digit before the frame closes overwrites it.
  - Zero or ≥2 bits low (other than 4'hf): o_err=1, no capture.
- Frame close:
  - Frame closes when mask==4'b1111, evaluated the cycle after the capture that completes it. mask is cleared on that same cycle.
  - If stage==prev and prev is marked filled: publish. o_bcd<=stage, o_valid<=1, and o_update pulses for 1 cycle only if stage != old o_bcd.
  - prev<=stage and prev filled<=1 on every frame close.
  - Latency: publish is 1 cycle after the frame-close cycle of the second matching frame.
- Once set, o_valid stays high until reset. A mismatching frame does not clear o_valid; o_bcd holds its old value.
- A capture and a frame close in the same cycle cannot collide, because a capture completes the mask and the close follows one cycle later.
- Captures arriving on the frame-close cycle go into the new frame, since the mask clear is applied before the set.
- o_err set and a publish in the same cycle: both take effect.

Decomposition:
- Package fnd_pkg: font constants FONT_0..FONT_9, FONT_DP, FONT_BLANK; COM_IDLE=4'hf; code constants CODE_BLANK=4'hf, CODE_BAD=4'he. The existing BCD→FND decoder migrates to the same constants.
- Sub-module fnd_font_decode: 8→4 combinational decode plus illegal flag, so the table is verified in isolation.
- Settle, capture and frame logic stay in the top module.

Test Plan:
- Scan "1234" (i_com 4'he/d/b/7 with fonts f9,a4,b0,99), each digit held 8 cycles with 2 cycles of 4'hf between, two full scans → o_bcd=16'h4321, o_valid=1, one o_update pulse, o_err=0.
- Continue the same scan for 10 frames → no further o_update; then change digit 0 to font 92 → after two frames o_bcd=16'h4325, one o_update.
- Glitch: digit 2 font toggled for 2 cycles (< SETTLE_CYC) mid-hold → ignored; o_bcd unchanged, o_err=0.
- Illegal font 8'h55 on digit 1 → o_err=1 and stays 1. Two frames with code E in digit 1 publish 16'h43E1 (on an otherwise 1234 scan).
- i_com=4'hc held 8 cycles → o_err=1, no capture; mask unaffected.
- Assert i_reset after 3 digits of the second frame → all outputs 0 next cycle; two fresh full frames are needed before o_valid=1.
